// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key schedule: one 32-bit word per clock into a local
// word store, with a registered 128-bit round-key read port.
//
// state  | meaning
// IDLE   | no schedule in progress; ready for a key
// EXPAND | generating w[Nk] .. w[4*Nr+3], one word per cycle
// DONE   | schedule complete; keys_valid asserts the following cycle
module aes_key_expander #(
  parameter  int MAX_NK = 8,
  localparam int KW     = 32 * MAX_NK
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_valid,
  output logic          key_ready,
  input  logic [KW-1:0] key,
  input  logic [1:0]    key_len,
  output logic          busy,
  output logic          keys_valid,
  output logic          cfg_err,
  input  logic          rk_rd_en,
  input  logic [3:0]    rk_rd_idx,
  output logic [127:0]  rk_rd_data,
  output logic          rk_rd_vld
);

  localparam int NW = 4 * (MAX_NK + 7);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] w_q [NW];
  logic [5:0]  i_q;
  logic [2:0]  mod_q;
  logic [3:0]  nk_q, nr_q;
  logic [7:0]  rcon_q;
  logic        keys_valid_q, cfg_err_q;
  logic [127:0] rd_data_q;
  logic        rd_vld_q;

  logic [3:0]  nk_new, nr_new;
  logic        len_ok, accept, acc_ok, acc_bad, last_word, rd_ok;
  logic [31:0] prev_w, back_w, rot_w, sub_in, sub_out, temp_w, new_w;
  logic [5:0]  rd_base;

  always_comb begin
    nk_new = 4'd4;
    nr_new = 4'd10;
    len_ok = 1'b0;
    case (key_len)
      2'b00: begin nk_new = 4'd4; nr_new = 4'd10; len_ok = (MAX_NK >= 4); end
      2'b01: begin nk_new = 4'd6; nr_new = 4'd12; len_ok = (MAX_NK >= 6); end
      2'b10: begin nk_new = 4'd8; nr_new = 4'd14; len_ok = (MAX_NK >= 8); end
      default: ;
    endcase
  end

  assign accept    = key_valid && key_ready;
  assign acc_ok    = accept && len_ok;
  assign acc_bad   = accept && !len_ok;
  assign last_word = (i_q == {nr_q, 2'b11});

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (acc_ok)       state_d = S_EXPAND;
        else if (acc_bad) state_d = S_IDLE;
      end
      S_EXPAND: if (last_word) state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    key_ready = (state_q == S_IDLE) || (state_q == S_DONE);
    busy      = (state_q == S_EXPAND);
  end

  // Key-schedule recurrence; mod_q tracks i % Nk without a divider.
  always_comb begin
    prev_w  = w_q[i_q - 6'd1];
    back_w  = w_q[i_q - {2'b00, nk_q}];
    rot_w   = {prev_w[23:0], prev_w[31:24]};
    sub_in  = (mod_q == 3'd0) ? rot_w : prev_w;
    sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    if (mod_q == 3'd0)                         temp_w = sub_out ^ {rcon_q, 24'h000000};
    else if (nk_q == 4'd8 && mod_q == 3'd4)    temp_w = sub_out;
    else                                       temp_w = prev_w;
    new_w = back_w ^ temp_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NW; j++) w_q[j] <= 32'h0;
      i_q          <= 6'd0;
      mod_q        <= 3'd0;
      nk_q         <= 4'd4;
      nr_q         <= 4'd10;
      rcon_q       <= 8'h01;
      keys_valid_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      cfg_err_q <= acc_bad;
      if (acc_ok) begin
        for (int j = 0; j < MAX_NK; j++)
          if (4'(j) < nk_new) w_q[j] <= key[KW-1-32*j -: 32];
        i_q    <= {2'b00, nk_new};
        mod_q  <= 3'd0;
        nk_q   <= nk_new;
        nr_q   <= nr_new;
        rcon_q <= 8'h01;
      end else if (state_q == S_EXPAND) begin
        w_q[i_q] <= new_w;
        i_q      <= i_q + 6'd1;
        mod_q    <= ({1'b0, mod_q} == nk_q - 4'd1) ? 3'd0 : mod_q + 3'd1;
        if (mod_q == 3'd0)
          rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      end
      if (accept)                 keys_valid_q <= 1'b0;
      else if (state_q == S_DONE) keys_valid_q <= 1'b1;
    end
  end

  assign rd_base = {rk_rd_idx, 2'b00};
  assign rd_ok   = rk_rd_en && keys_valid_q && (rk_rd_idx <= nr_q);

  // Rejected reads leave the previous round key on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= 128'h0;
      rd_vld_q  <= 1'b0;
    end else begin
      rd_vld_q <= rd_ok;
      if (rd_ok)
        rd_data_q <= {w_q[rd_base], w_q[rd_base | 6'd1], w_q[rd_base | 6'd2], w_q[rd_base | 6'd3]};
    end
  end

  assign keys_valid = keys_valid_q;
  assign cfg_err    = cfg_err_q;
  assign rk_rd_data = rd_data_q;
  assign rk_rd_vld  = rd_vld_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using FIPS-197 key-expansion vectors.
module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic         key_ready;
  logic [255:0] key;
  logic [1:0]   key_len;
  logic         busy, keys_valid, cfg_err;
  logic         rk_rd_en;
  logic [3:0]   rk_rd_idx;
  logic [127:0] rk_rd_data;
  logic         rk_rd_vld;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [127:0] R128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R128_9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R192_0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
  localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256_0  = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] R256_1  = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  aes_key_expander #(.MAX_NK(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key        (key),
    .key_len    (key_len),
    .busy       (busy),
    .keys_valid (keys_valid),
    .cfg_err    (cfg_err),
    .rk_rd_en   (rk_rd_en),
    .rk_rd_idx  (rk_rd_idx),
    .rk_rd_data (rk_rd_data),
    .rk_rd_vld  (rk_rd_vld)
  );

  always #5 clk = ~clk;

  task automatic accept_key(input logic [255:0] k, input logic [1:0] len);
    @(negedge clk);
    key = k; key_len = len; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (keys_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic rd(input logic [3:0] idx);
    @(negedge clk);
    rk_rd_en = 1'b1; rk_rd_idx = idx;
    @(posedge clk); #1;
    rk_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready: got %b expected 1", key_ready); end
    checks++; if (keys_valid !== 1'b0) begin errors++; $display("FAIL reset_keys_valid: got %b expected 0", keys_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (cfg_err !== 1'b0 || rk_rd_vld !== 1'b0) begin errors++; $display("FAIL reset_pulses: got cfg_err=%b rd_vld=%b expected 0/0", cfg_err, rk_rd_vld); end
    checks++; if (rk_rd_data !== 128'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rk_rd_data); end
    @(negedge clk); rst = 1'b0;
    rd(4'd0);
    checks++; if (rk_rd_vld !== 1'b0) begin errors++; $display("FAIL read_before_keys: got vld=%b expected 0", rk_rd_vld); end
  endtask

  task automatic test_aes128();
    int n;
    accept_key(K128, 2'b00);
    checks++; if (busy !== 1'b1 || key_ready !== 1'b0) begin errors++; $display("FAIL a128_busy: got busy=%b ready=%b expected 1/0", busy, key_ready); end
    wait_valid(n);
    checks++; if (n != 41) begin errors++; $display("FAIL a128_latency: got %0d expected 41", n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a128_busy_done: got %b expected 0", busy); end
    rd(4'd10);
    checks++; if (rk_rd_vld !== 1'b1 || rk_rd_data !== R128_10) begin errors++; $display("FAIL a128_round10: got vld=%b %h expected 1 %h", rk_rd_vld, rk_rd_data, R128_10); end
    rd(4'd0);
    checks++; if (rk_rd_data !== R128_0) begin errors++; $display("FAIL a128_round0: got %h expected %h", rk_rd_data, R128_0); end
    rd(4'd1);
    checks++; if (rk_rd_data !== R128_1) begin errors++; $display("FAIL a128_round1: got %h expected %h", rk_rd_data, R128_1); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); rk_rd_en = 1'b1; rk_rd_idx = 4'd9;
    @(posedge clk); #1;
    checks++; if (rk_rd_vld !== 1'b1 || rk_rd_data !== R128_9) begin errors++; $display("FAIL b2b_round9: got vld=%b %h expected 1 %h", rk_rd_vld, rk_rd_data, R128_9); end
    @(negedge clk); rk_rd_idx = 4'd10;
    @(posedge clk); #1;
    rk_rd_en = 1'b0;
    checks++; if (rk_rd_vld !== 1'b1 || rk_rd_data !== R128_10) begin errors++; $display("FAIL b2b_round10: got vld=%b %h expected 1 %h", rk_rd_vld, rk_rd_data, R128_10); end
    rd(4'd11);
    checks++; if (rk_rd_vld !== 1'b0) begin errors++; $display("FAIL idx11_vld: got %b expected 0", rk_rd_vld); end
    checks++; if (rk_rd_data !== R128_10) begin errors++; $display("FAIL idx11_hold: got %h expected %h", rk_rd_data, R128_10); end
  endtask

  task automatic test_aes192();
    int n;
    accept_key(K192, 2'b01);
    checks++; if (keys_valid !== 1'b0) begin errors++; $display("FAIL a192_reload_clear: got %b expected 0", keys_valid); end
    wait_valid(n);
    checks++; if (n != 47) begin errors++; $display("FAIL a192_latency: got %0d expected 47", n); end
    rd(4'd12);
    checks++; if (rk_rd_vld !== 1'b1 || rk_rd_data !== R192_12) begin errors++; $display("FAIL a192_round12: got vld=%b %h expected 1 %h", rk_rd_vld, rk_rd_data, R192_12); end
    rd(4'd0);
    checks++; if (rk_rd_data !== R192_0) begin errors++; $display("FAIL a192_round0: got %h expected %h", rk_rd_data, R192_0); end
    rd(4'd13);
    checks++; if (rk_rd_vld !== 1'b0) begin errors++; $display("FAIL a192_idx13: got vld=%b expected 0", rk_rd_vld); end
  endtask

  task automatic test_aes256();
    int n;
    accept_key(K256, 2'b10);
    wait_valid(n);
    checks++; if (n != 53) begin errors++; $display("FAIL a256_latency: got %0d expected 53", n); end
    rd(4'd14);
    checks++; if (rk_rd_vld !== 1'b1 || rk_rd_data !== R256_14) begin errors++; $display("FAIL a256_round14: got vld=%b %h expected 1 %h", rk_rd_vld, rk_rd_data, R256_14); end
    rd(4'd0);
    checks++; if (rk_rd_data !== R256_0) begin errors++; $display("FAIL a256_round0: got %h expected %h", rk_rd_data, R256_0); end
    rd(4'd1);
    checks++; if (rk_rd_data !== R256_1) begin errors++; $display("FAIL a256_round1: got %h expected %h", rk_rd_data, R256_1); end
  endtask

  task automatic test_busy_ignore();
    int n;
    accept_key(K128, 2'b00);
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk); key = K256; key_len = 2'b10; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy: got %b expected 1", busy); end
    wait_valid(n);
    checks++; if (n + 6 != 41) begin errors++; $display("FAIL ignore_latency: got %0d expected 41", n + 6); end
    rd(4'd10);
    checks++; if (rk_rd_data !== R128_10) begin errors++; $display("FAIL ignore_round10: got %h expected %h", rk_rd_data, R128_10); end
  endtask

  task automatic test_reset_mid();
    int n;
    accept_key(K128, 2'b00);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || key_ready !== 1'b1) begin errors++; $display("FAIL midrst_state: got busy=%b ready=%b expected 0/1", busy, key_ready); end
    checks++; if (keys_valid !== 1'b0 || rk_rd_data !== 128'h0) begin errors++; $display("FAIL midrst_clear: got valid=%b data=%h expected 0/0", keys_valid, rk_rd_data); end
    @(negedge clk); rst = 1'b0;
    accept_key(K128, 2'b00);
    wait_valid(n);
    checks++; if (n != 41) begin errors++; $display("FAIL midrst_latency: got %0d expected 41", n); end
    rd(4'd10);
    checks++; if (rk_rd_data !== R128_10) begin errors++; $display("FAIL midrst_round10: got %h expected %h", rk_rd_data, R128_10); end
  endtask

  task automatic test_cfg_err();
    int n;
    accept_key(K256, 2'b11);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfgerr_pulse: got %b expected 1", cfg_err); end
    checks++; if (keys_valid !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1) begin errors++; $display("FAIL cfgerr_state: got valid=%b busy=%b ready=%b expected 0/0/1", keys_valid, busy, key_ready); end
    @(posedge clk); #1;
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfgerr_one_cycle: got %b expected 0", cfg_err); end
    checks++; if (keys_valid !== 1'b0) begin errors++; $display("FAIL cfgerr_stays_invalid: got %b expected 0", keys_valid); end
    rd(4'd0);
    checks++; if (rk_rd_vld !== 1'b0) begin errors++; $display("FAIL cfgerr_read: got vld=%b expected 0", rk_rd_vld); end
    accept_key(K128, 2'b00);
    wait_valid(n);
    checks++; if (n != 41) begin errors++; $display("FAIL cfgerr_recover_latency: got %0d expected 41", n); end
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key = '0; key_len = 2'b00;
    rk_rd_en = 1'b0; rk_rd_idx = 4'd0;
    test_reset();
    test_aes128();
    test_back_to_back();
    test_aes192();
    test_aes256();
    test_busy_ignore();
    test_reset_mid();
    test_cfg_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
